// File: rtl/piso.sv
// rtl/piso.sv - parallel-in/serial-out readback engine, LSB-first with per-bit valid
module piso #(
    parameter int AES_W = 128,
    parameter int MEM_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [1:0]       instruction,
    input  logic [AES_W-1:0] aes_data_i,
    input  logic [MEM_W-1:0] mem_data_i,
    output logic             data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_AES = CNT_W'(AES_W);
    localparam logic [CNT_W-1:0] CNT_MEM = CNT_W'(MEM_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [AES_W-1:0] sr;
    logic [CNT_W-1:0] cnt;

    // State register; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: only legal sources start a transfer; a stalled last bit waits for en
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load && !instruction[1]) state_nxt = S_SHIFT;
            S_SHIFT: if (en && cnt == CNT_ONE)    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Busy covers the whole transfer including the completion cycle
    always_comb begin
        busy_o = (state == S_SHIFT) || (state == S_DONE);
    end

    // Datapath: capture at load, shift one bit per enabled cycle, pulse flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            data_o  <= 1'b0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        if (instruction == 2'b00) begin
                            sr  <= aes_data_i;
                            cnt <= CNT_AES;
                        end else if (instruction == 2'b01) begin
                            sr  <= AES_W'(mem_data_i);
                            cnt <= CNT_MEM;
                        end else begin
                            // key material is never a readback source
                            err_o <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (en) begin
                        data_o  <= sr[0];
                        valid_o <= 1'b1;
                        sr      <= sr >> 1;
                        cnt     <= cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piso.sv
// tb/tb_piso.sv - randomized and directed readback checks against a word-level model
module tb_piso;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [1:0]   instruction = 2'b00;
    logic [127:0] aes_data_i = '0;
    logic [31:0]  mem_data_i = '0;
    logic         data_o;
    logic         valid_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    int checks = 0;
    int errors = 0;

    piso #(.AES_W(128), .MEM_W(32), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .instruction(instruction),
        .aes_data_i(aes_data_i),
        .mem_data_i(mem_data_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One readback. mode 1 toggles en randomly; stall_at drops en for 5 edges after that
    // many bits; reload_at pulses a MEM load after that many bits. The model: bit i of the
    // word appears on the i-th enabled edge, done follows the N-th enabled edge by one.
    task automatic xfer(input logic [1:0] ins, input logic [127:0] word, input int mode,
                        input int stall_at, input int reload_at, input string tag);
        int           n;
        int           got;
        int           nen;
        int           edge_i;
        int           last_edge;
        int           done_edge;
        int           stall_left;
        bit           reloaded;
        logic         exp_valid;
        logic [127:0] w;
        logic [127:0] rw;
        n = (ins == 2'b00) ? 128 : 32;
        w = (ins == 2'b00) ? word : {96'b0, word[31:0]};
        rw = '0;
        got = 0; nen = 0; edge_i = 0; last_edge = -1; done_edge = -1;
        stall_left = 0; reloaded = 0;
        instruction = ins;
        aes_data_i = word;
        mem_data_i = word[31:0];
        en = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        aes_data_i = ~word;
        mem_data_i = ~word[31:0];
        chk(busy_o, 1'b1, {tag, "_busy_after_load"});
        while (done_edge < 0 && edge_i < n * 4 + 40) begin
            if (stall_left > 0) begin
                en = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                en = ($urandom % 3) != 0;
            end else begin
                en = 1'b1;
            end
            if (reload_at >= 0 && got == reload_at && !reloaded) begin
                load = 1'b1;
                instruction = 2'b01;
                reloaded = 1;
            end else begin
                load = 1'b0;
            end
            exp_valid = en && (nen < n);
            tick();
            edge_i++;
            if (exp_valid) begin
                nen++;
                if (nen == n) last_edge = edge_i;
            end
            if (valid_o !== exp_valid || done_o !== (last_edge >= 0 && edge_i == last_edge + 1))
            begin
                chk(valid_o, exp_valid, {tag, "_valid"});
                chk(done_o, (last_edge >= 0 && edge_i == last_edge + 1), {tag, "_done_timing"});
            end
            if (valid_o === 1'b1 && got < 128) begin
                rw[got] = data_o;
                got++;
                if (got == stall_at) stall_left = 5;
            end
            if (done_o === 1'b1) begin
                done_edge = edge_i;
                chk(busy_o, 1'b0, {tag, "_busy_drops"});
            end
        end
        load = 1'b0;
        en = 1'b1;
        chk(got, n, {tag, "_bit_count"});
        chk(rw, w, {tag, "_word"});
        chk(done_edge, last_edge + 1, {tag, "_done_edge_model"});
        if (mode == 0) chk(done_edge, n + 1 + ((stall_at >= 0) ? 5 : 0), {tag, "_done_edge"});
        tick();
        chk(done_o, 1'b0, {tag, "_done_one_cycle"});
    endtask

    initial begin
        logic         d_prev;
        logic [127:0] rw;
        int           got;
        int           guard;

        tick();
        chk({data_o, valid_o, busy_o, done_o, err_o}, 5'b0, "reset_outputs");
        rst = 1'b0;
        tick();
        chk({valid_o, busy_o, done_o, err_o}, 4'b0, "idle_outputs");

        // AES readback, 129-cycle done
        xfer(2'b00, 128'h0123456789abcdef0123456789abcdef, 0, -1, -1, "aes");
        // MEM readback, 33-cycle done
        xfer(2'b01, 128'h00000000_00000000_00000000_A5A50001, 0, -1, -1, "mem");
        // MEM readback with 5-cycle stall after bit 10
        xfer(2'b01, 128'h00000000_00000000_00000000_A5A50001, 0, 10, -1, "stall");

        // illegal sources: one err pulse per load, nothing else moves
        for (int k = 0; k < 2; k++) begin
            d_prev = data_o;
            instruction = (k == 0) ? 2'b10 : 2'b11;
            load = 1'b1;
            tick();
            load = 1'b0;
            chk(err_o, 1'b1, "illegal_err");
            chk({busy_o, valid_o}, 2'b0, "illegal_idle");
            chk(data_o, d_prev, "illegal_data_hold");
            tick();
            chk(err_o, 1'b0, "illegal_err_pulse");
            chk(busy_o, 1'b0, "illegal_busy");
        end

        // re-load mid-AES is ignored
        xfer(2'b00, 128'hfedcba98_76543210_0f1e2d3c_4b5a6978, 0, -1, 60, "reload");

        // reset abort after bit 40
        instruction = 2'b00;
        aes_data_i = {$urandom, $urandom, $urandom, $urandom};
        en = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        got = 0;
        guard = 0;
        rw = '0;
        while (got < 40 && guard < 200) begin
            tick();
            guard++;
            if (valid_o === 1'b1) begin
                rw[got] = data_o;
                got++;
            end
        end
        chk(got, 40, "abort_reached_bit40");
        chk(rw[39:0], aes_data_i[39:0], "abort_prefix");
        rst = 1'b1;
        #1;
        chk({data_o, valid_o, busy_o, done_o, err_o}, 5'b0, "abort_async_clear");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk(done_o, 1'b0, "abort_no_done");
        end
        rst = 1'b0;
        tick();
        xfer(2'b01, {96'b0, $urandom}, 0, -1, -1, "after_abort");

        // randomized transfers with random en stalls
        for (int k = 0; k < 6; k++) begin
            xfer({1'b0, 1'($urandom % 2)}, {$urandom, $urandom, $urandom, $urandom},
                 1, -1, -1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
